// File: rtl/err_gen_pkg.sv
// err_gen_pkg: shared widths, FSM state enum and saturation limits for the heading-error path
package err_gen_pkg;
   localparam int HDNG_W = 12;
   localparam int ERR_W  = 10;
   localparam logic signed [ERR_W-1:0] SAT_POS = 10'h1FF;
   localparam logic signed [ERR_W-1:0] SAT_NEG = 10'h200;
   typedef enum logic [0:0] {IDLE = 1'b0, FILL = 1'b1} state_e;
endpackage

// File: rtl/err_gen_if.sv
// err_gen_if: heading sample inputs and averaged error outputs of err_gen
interface err_gen_if;
   import err_gen_pkg::*;
   logic signed [HDNG_W-1:0] actual_hdng;
   logic signed [HDNG_W-1:0] dsrd_hdng;
   logic                     hdng_vld;
   logic                     moving;
   logic signed [ERR_W-1:0]  err_sat;
   logic                     err_vld;
   modport master (output actual_hdng, hdng_vld, dsrd_hdng, moving, input err_sat, err_vld);
   modport slave (input actual_hdng, hdng_vld, dsrd_hdng, moving, output err_sat, err_vld);
endinterface

// File: rtl/sat_s12_s10.sv
// sat_s12_s10: clamps a signed 12-bit value into signed 10-bit range
module sat_s12_s10
   import err_gen_pkg::*;
(
   input  logic signed [HDNG_W-1:0] a,
   output logic signed [ERR_W-1:0]  y
);
   // value fits when all bits above the 10-bit sign bit equal it
   always_comb
      y = (&a[HDNG_W-1:ERR_W-1] || ~|a[HDNG_W-1:ERR_W-1]) ? a[ERR_W-1:0] :
          a[HDNG_W-1] ? SAT_NEG : SAT_POS;
endmodule

// File: rtl/err_gen.sv
// err_gen: averages 2^AVG_LOG2 wrapped heading errors and emits a saturated 10-bit error
module err_gen
   import err_gen_pkg::*;
#(
   parameter int AVG_LOG2 = 2
) (
   input logic       clk,
   input logic       rst_n,
   err_gen_if.slave  bus
);
   localparam int AW = HDNG_W + AVG_LOG2;
   localparam int CW = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
   localparam logic [CW-1:0] LAST = CW'((1 << AVG_LOG2) - 1);
   localparam logic [0:0] ST_IDLE = IDLE;
   localparam logic [0:0] ST_FILL = FILL;
   logic [0:0]               state, state_nx;
   logic signed [AW-1:0]     acc, acc_base, acc_nx, sum;
   logic [CW-1:0]            cnt, cnt_base, cnt_nx;
   logic signed [HDNG_W-1:0] dsrd_q, diff, avg;
   logic signed [ERR_W-1:0]  sat;
   logic                     accept, restart, done, clr;
   // window bookkeeping: a dsrd change or IDLE restarts the window so the current sample is first
   always_comb begin
      diff     = bus.actual_hdng - bus.dsrd_hdng;
      restart  = (state == ST_IDLE) || (bus.dsrd_hdng != dsrd_q);
      acc_base = restart ? '0 : acc;
      cnt_base = restart ? '0 : cnt;
      accept   = bus.hdng_vld && bus.moving;
      sum      = acc_base + AW'(diff);
      avg      = HDNG_W'(sum >>> AVG_LOG2);
      done     = accept && (cnt_base == LAST);
      clr      = !bus.moving || done;
      state_nx = bus.moving ? ST_FILL : ST_IDLE;
      acc_nx   = clr ? '0 : accept ? sum : acc_base;
      cnt_nx   = clr ? '0 : accept ? cnt_base + 1'b1 : cnt_base;
   end
   sat_s12_s10 u_sat (
      .a (avg),
      .y (sat)
   );
   // state, window and output registers; err_sat only moves on a completed window
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state       <= ST_IDLE;
         acc         <= '0;
         cnt         <= '0;
         dsrd_q      <= '0;
         bus.err_sat <= '0;
         bus.err_vld <= 1'b0;
      end else begin
         state       <= state_nx;
         acc         <= acc_nx;
         cnt         <= cnt_nx;
         dsrd_q      <= bus.dsrd_hdng;
         bus.err_vld <= done;
         if (done) bus.err_sat <= sat;
      end
endmodule

// File: tb/tb_err_gen.sv
// tb_err_gen: directed scenarios checked against a window-averaging model every cycle
module tb_err_gen;
   logic clk = 1'b0;
   logic rst_n;
   int checks = 0;
   int errors = 0;
   err_gen_if bus ();
   err_gen #(.AVG_LOG2(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   int mw[4], nw[4];
   int mn, nn, s, a;
   logic signed [11:0] mlast, d12;
   logic mvld, nvld;
   logic [9:0] msat, nsat;
   // model: collect wrapped diffs of the current window, average the 4th with floor division
   always_comb begin
      nw = mw; nn = mn; nvld = 1'b0; nsat = msat; d12 = '0; s = 0; a = 0;
      if (bus.dsrd_hdng != mlast || !bus.moving) nn = 0;
      if (bus.moving && bus.hdng_vld) begin
         d12 = bus.actual_hdng - bus.dsrd_hdng;
         nw[nn] = int'(d12);
         nn = nn + 1;
         if (nn == 4) begin
            s = nw[0] + nw[1] + nw[2] + nw[3];
            a = s >>> 2;
            nsat = (a > 511) ? 10'h1FF : (a < -512) ? 10'h200 : 10'(a);
            nvld = 1'b1;
            nn = 0;
         end
      end
   end
   // model registers
   always @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         mn <= 0; mlast <= '0; mvld <= 1'b0; msat <= '0;
      end else begin
         mw <= nw; mn <= nn; mlast <= bus.dsrd_hdng; mvld <= nvld; msat <= nsat;
      end
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
      end
   endtask
   // every-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      chk("cyc_vld", {31'b0, bus.err_vld}, {31'b0, mvld});
      chk("cyc_sat", {22'b0, $unsigned(bus.err_sat)}, {22'b0, msat});
   end
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic samp(input logic signed [11:0] v);
      bus.actual_hdng = v;
      bus.hdng_vld = 1'b1;
      step();
      bus.hdng_vld = 1'b0;
   endtask
   task automatic win4(input logic signed [11:0] v, input string nm, input logic [9:0] e);
      for (int i = 0; i < 4; i++) begin
         samp(v);
         if (i < 3) begin
            chk({nm, "_pre"}, {31'b0, bus.err_vld}, 32'd0);
            step();
         end
      end
      chk({nm, "_vld"}, {31'b0, bus.err_vld}, 32'd1);
      chk({nm, "_sat"}, {22'b0, $unsigned(bus.err_sat)}, {22'b0, e});
      step();
      chk({nm, "_once"}, {31'b0, bus.err_vld}, 32'd0);
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1);
   end
   initial begin
      rst_n = 1'b0;
      bus.moving = 1'b0; bus.hdng_vld = 1'b0; bus.actual_hdng = '0; bus.dsrd_hdng = '0;
      repeat (3) step();
      chk("rst_vld", {31'b0, bus.err_vld}, 32'd0);
      chk("rst_sat", {22'b0, $unsigned(bus.err_sat)}, 32'd0);
      rst_n = 1'b1;
      step();
      bus.moving = 1'b1;
      step();
      win4(12'sd100, "s1", 10'd100);
      bus.dsrd_hdng = 12'h7F0;
      step();
      win4(12'h810, "s2", 10'd32);
      bus.dsrd_hdng = '0;
      step();
      win4(12'sd1000, "s3p", 10'h1FF);
      win4(-12'sd1000, "s3n", 10'h200);
      samp(12'sd80); step();
      samp(12'sd80);
      chk("s4_mid", {31'b0, bus.err_vld}, 32'd0);
      step();
      bus.dsrd_hdng = 12'sd50;
      win4(12'sd130, "s4", 10'd80);
      samp(12'sd20); step();
      samp(12'sd20); step();
      samp(12'sd20); step();
      bus.moving = 1'b0;
      repeat (3) step();
      chk("s5_hold", {22'b0, $unsigned(bus.err_sat)}, 32'd80);
      bus.moving = 1'b1;
      step();
      win4(12'sd60, "s5", 10'd10);
      samp(12'sd43); step();
      samp(12'sd43); step();
      rst_n = 1'b0;
      #1;
      chk("s6_rvld", {31'b0, bus.err_vld}, 32'd0);
      chk("s6_rsat", {22'b0, $unsigned(bus.err_sat)}, 32'd0);
      step();
      rst_n = 1'b1;
      step();
      win4(12'sd43, "s6", 10'h3F9);
      bus.dsrd_hdng = '0;
      step();
      samp(-12'sd1); step(); samp(12'sd0); step(); samp(12'sd0); step(); samp(12'sd0);
      chk("s7_floor", {22'b0, $unsigned(bus.err_sat)}, 32'h3FF);
      step();
      samp(12'sd1); step(); samp(12'sd0); step(); samp(12'sd0); step(); samp(12'sd0);
      chk("s7_trunc", {22'b0, $unsigned(bus.err_sat)}, 32'd0);
      repeat (4) step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/err_gen.md
ERR_GEN -- requirements
Module: err_gen

Interface
REQ-001 SHALL have parameter AVG_LOG2, default 2, log2 of the number of heading samples averaged per error update (legal range 0..3).
REQ-002 SHALL have port clk, input, 1, system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port actual_hdng, input, 12 signed, measured heading, where the 12-bit range spans a full circle.
REQ-005 SHALL have port hdng_vld, input, 1, one-cycle strobe qualifying actual_hdng.
REQ-006 SHALL have port dsrd_hdng, input, 12 signed, commanded heading; it is level-sampled every cycle.
REQ-007 SHALL have port moving, input, 1, enables error generation when high.
REQ-008 SHALL have port err_sat, output, 10 signed, saturated averaged heading error consumed by the P/I/D term blocks.
REQ-009 SHALL have port err_vld, output, 1, one-cycle strobe marking a new err_sat value.

Function
REQ-010 SHALL compute diff = actual_hdng - dsrd_hdng modulo 2^12, so wrap-around yields the shortest signed angle.
REQ-011 SHALL sign-extend diff into an accumulator of 12+AVG_LOG2 bits and add it on each accepted sample.
REQ-012 SHALL accept a sample only when hdng_vld is high and moving is high in the same cycle.
REQ-013 SHALL implement a state machine with states IDLE and FILL, plus a sample counter of AVG_LOG2 bits (1 bit when AVG_LOG2=0).
REQ-014 In IDLE, the block SHALL hold the accumulator and counter at 0; moving high moves it to FILL on the next cycle; a sample in that same cycle is accepted as the first sample.
REQ-015 In FILL, moving low SHALL return the block to IDLE, clear the accumulator and counter, and discard the partial window without emitting err_vld.
REQ-016 Completion: when the 2^AVG_LOG2-th sample is accepted, the block SHALL compute avg = (accumulator + diff) >>> AVG_LOG2 (arithmetic shift).
REQ-017 On completion, the block SHALL register the saturated avg into err_sat, pulse err_vld for exactly the next cycle, and clear the accumulator and counter.
REQ-018 Saturation from the 12-bit avg to 10 bits SHALL be: avg > 511 gives 0x1FF; avg < -512 gives 0x200; otherwise avg[9:0].
REQ-019 SHALL keep a registered copy of dsrd_hdng; when dsrd_hdng differs from that copy, the block SHALL restart the window by clearing the accumulator and counter.
REQ-020 If a sample is accepted in the same cycle as a dsrd_hdng change, that sample SHALL become the first sample of the new window, computed against the new dsrd_hdng.
REQ-021 err_sat SHALL hold its last value between err_vld pulses, including while in IDLE.
REQ-022 err_vld SHALL never be high on two consecutive cycles, because hdng_vld spacing is at least 2 cycles by system contract.
REQ-023 Latency SHALL be exactly 1 clock from the completing hdng_vld to err_vld and the updated err_sat.

Reset
REQ-024 On rst_n low, the block SHALL asynchronously force state to IDLE, accumulator to 0, counter to 0, the dsrd_hdng copy to 0, err_sat to 0 and err_vld to 0.
REQ-025 Reset asserted mid-window SHALL discard the partial window.
REQ-026 After reset, the first err_vld SHALL require a full 2^AVG_LOG2 accepted samples.

Structure
REQ-027 A shared package err_gen_pkg SHALL hold the state enum (IDLE, FILL), HDNG_W=12, ERR_W=10, and the saturation limits 0x1FF and 0x200.
REQ-028 The 12-to-10 signed saturation SHALL be a combinational sub-module sat_s12_s10, reusable by the other PID term blocks.
REQ-029 All storage SHALL be inside this module; there SHALL be no combinational path from inputs to err_vld.

Verification (AVG_LOG2=2)
REQ-030 Scenario 1: moving=1, dsrd=0, four hdng_vld with actual=100 -> err_vld exactly 1 cycle after the 4th strobe, err_sat=100.
REQ-031 Scenario 2: dsrd=0x7F0, actual=0x810 four times -> err_sat=+32, which checks the wrap-around case.
REQ-032 Scenario 3: dsrd=0 with actual=1000 four times -> err_sat=0x1FF; then actual=-1000 four times -> err_sat=0x200.
REQ-033 Scenario 4: dsrd changes from 0 to 50 after 2 samples -> no err_vld until 4 further samples; the result then uses dsrd=50.
REQ-034 Scenario 5: moving drops after 3 samples -> no err_vld, err_sat holds its prior value; when moving rises again, 4 new samples are required.
REQ-035 Scenario 6: rst_n pulsed after 2 samples -> err_sat=0, err_vld=0; the next err_vld comes only after 4 post-reset samples.
